// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: request/acknowledge bus between the data-memory controller
// (master) and the memory or bus fabric (slave).
interface dmem_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    output bus_be,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    input  bus_be,
    output bus_ack,
    output bus_rdata
  );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: MEM-stage data memory controller. Turns a pipeline load/store
// into a single bus transaction, stalls the pipeline while it is in flight
// and returns the sign/zero-extended load result.
// Optional BUSY timeout abort: define DMEM_TIMEOUT_EN.
//
// state | meaning
// IDLE  | nothing in flight; a qualifying request is latched here
// BUSY  | bus_req held with stable addr/data/be until bus_ack
// DONE  | one-cycle completion; pipeline released, load_valid for reads
module dmem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               exmem_mem_r,
  input  logic               exmem_mem_w,
  input  logic [31:0]        exmem_alu_res,
  input  logic [31:0]        exmem_aligned_rt_data,
  input  logic [3:0]         mem_byte_w_en,
  input  logic [2:0]         exmem_load_sel,
  dmem_ctrl_if.master        bus,
  output logic               mem_stall,
  output logic [31:0]        load_data,
  output logic               load_valid,
  output logic               bus_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        access;
  logic        abort;
  logic        we_q;
  logic [2:0]  sel_q;
  logic [1:0]  lane_q;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext_data;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("dmem_ctrl: TIMEOUT_CYCLES must be within 1..255");
  end

  // A store with no byte enables retires without touching the bus; when both
  // request lines are high the store wins and the load is dropped.
  assign access = exmem_mem_w ? (|mem_byte_w_en) : exmem_mem_r;

`ifdef DMEM_TIMEOUT_EN
  logic [7:0] cnt;

  assign abort = (state == ST_BUSY) && !bus.bus_ack &&
                 (cnt == 8'(TIMEOUT_CYCLES - 1));

  // Count BUSY cycles for the current access and flag an abort for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= abort;
      if (state == ST_BUSY)
        cnt <= cnt + 8'd1;
      else
        cnt <= '0;
    end
  end
`else
  assign abort   = 1'b0;
  assign bus_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic; DONE always returns to IDLE so back-to-back accesses
  // see one IDLE cycle in between.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (access) state_nxt = ST_BUSY;
      ST_BUSY: if (bus.bus_ack || abort) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs; the stall must be combinational so the pipeline
  // freezes in the same cycle the request appears.
  always_comb begin
    bus.bus_req = (state == ST_BUSY);
    bus.bus_we  = we_q;
    mem_stall   = ((state == ST_IDLE) && access) || (state == ST_BUSY);
    load_valid  = (state == ST_DONE) && !we_q;
  end

  // Lane selection and extension of the returned word.
  always_comb begin
    byte_v = bus.bus_rdata[{lane_q, 3'b000} +: 8];
    half_v = lane_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (sel_q)
      3'd1:    ext_data = {{24{byte_v[7]}}, byte_v};
      3'd2:    ext_data = {24'h000000, byte_v};
      3'd3:    ext_data = {{16{half_v[15]}}, half_v};
      3'd4:    ext_data = {16'h0000, half_v};
      default: ext_data = bus.bus_rdata;
    endcase
  end

  // Latch the access in IDLE so the bus stays stable through BUSY, and
  // capture the load result when it completes or is aborted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      bus.bus_be    <= '0;
      we_q          <= 1'b0;
      sel_q         <= '0;
      lane_q        <= '0;
      load_data     <= '0;
    end else begin
      if (state == ST_IDLE && access) begin
        bus.bus_addr  <= {exmem_alu_res[31:2], 2'b00};
        bus.bus_wdata <= exmem_mem_w ? exmem_aligned_rt_data : 32'h0;
        bus.bus_be    <= exmem_mem_w ? mem_byte_w_en : 4'b1111;
        we_q          <= exmem_mem_w;
        sel_q         <= exmem_load_sel;
        lane_q        <= exmem_alu_res[1:0];
      end
      if (state == ST_BUSY && !we_q) begin
        if (bus.bus_ack)
          load_data <= ext_data;
        else if (abort)
          load_data <= '0;
      end
    end
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, BUSY cycles without bus_ack before abort (8-bit counter, valid 1..255).
REQ-002 SHALL have ports, one per line (name direction width meaning):
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high.
- exmem_mem_r  in  1  MEM-stage load request.
- exmem_mem_w  in  1  MEM-stage store request.
- exmem_alu_res  in  32  byte address.
- exmem_aligned_rt_data  in  32  store data, already lane-aligned.
- mem_byte_w_en  in  4  store byte enables.
- exmem_load_sel  in  3  load type.
- bus_req  out  1  bus request, held until ack.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address {addr[31:2],2'b00}.
- bus_wdata  out  32  write data.
- bus_be  out  4  byte enables; 4'b1111 on reads.
- bus_ack  in  1  one-cycle completion strobe.
- bus_rdata  in  32  read data, valid with bus_ack.
- mem_stall  out  1  stall request to control unit.
- load_data  out  32  extended load result.
- load_valid  out  1  load result valid, one cycle.
- bus_err  out  1  timeout abort pulse.

Function
REQ-003 SHALL implement FSM IDLE, BUSY, DONE.
REQ-004 IDLE: request present (mem_r or mem_w) -> register address/data/be/load_sel/type, go BUSY; bus_req=1 from next cycle.
REQ-005 Both mem_r and mem_w high SHALL be treated as write; read ignored.
REQ-006 mem_w with mem_byte_w_en==0 SHALL complete with no bus transaction, no stall, remain IDLE.
REQ-007 mem_stall SHALL be combinational: 1 when (IDLE and qualifying request) or BUSY; 0 in DONE and otherwise.
REQ-008 BUSY: bus_req, bus_we, bus_addr, bus_wdata, bus_be SHALL stay stable until bus_ack sampled high; then bus_req drops next cycle, bus_rdata captured, go DONE.
REQ-009 DONE SHALL last exactly one cycle, then IDLE unconditionally; load_valid=1 in DONE for reads only.
REQ-010 Minimum access latency: request seen -> DONE in 3 cycles with ack in first BUSY cycle; back-to-back requests SHALL incur one IDLE cycle between.
REQ-011 load_sel: 0 word; 1 LB sign-ext; 2 LBU zero-ext; 3 LH sign-ext; 4 LHU zero-ext; 5-7 treated as word.
REQ-012 Byte lane = addr[1:0], halfword = addr[1], little-endian; misaligned halfword/word uses aligned word, no exception.
REQ-013 bus_ack outside BUSY SHALL be ignored.
REQ-014 load_data SHALL hold last value until next read completes.

Reset
REQ-015 Reset SHALL act immediately, mid-transaction included: state IDLE, bus_req/bus_we/load_valid/bus_err=0, bus_addr/bus_wdata/load_data=0, bus_be=0, counter=0.
REQ-016 An aborted in-flight access SHALL NOT be retried after reset.

Configuration
REQ-017 Macro DMEM_TIMEOUT_EN defined: counter increments each BUSY cycle; on reaching TIMEOUT_CYCLES without ack -> drop bus_req, bus_err=1 one cycle, DONE with load_data=0, load_valid=1 for reads.
REQ-018 DMEM_TIMEOUT_EN undefined: no counter, bus_err tied 0, BUSY waits indefinitely.

Verification
REQ-019 LW addr 0x100, ack after 2 BUSY cycles, rdata 0xDEADBEEF -> bus_addr 0x100, stall 3 cycles, load_data 0xDEADBEEF, load_valid 1 cycle.
REQ-020 LB addr 0x103, rdata 0x80112233 -> load_data 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x00008011.
REQ-021 SW addr 0x204, be 4'b0011, data 0x0000ABCD -> bus_we=1, bus_be=0011, bus_wdata 0x0000ABCD; be 0 store -> no bus_req, no stall.
REQ-022 Reset asserted during BUSY -> bus_req 0 immediately, IDLE, no load_valid, stray later ack ignored.
REQ-023 DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> bus_err pulse after 4 BUSY cycles, load_data 0, stall released in DONE.
REQ-024 mem_r and mem_w both high -> single write transaction, load_valid stays 0.
